wptr_full_ctrl: RTL and testbench

- Write-domain pointer and status controller for the dual-clock FIFO.
- Consumes the 2-flop-synchronised Gray read pointer (wq2_rptr) and owns the write pointer in binary and Gray form.
- Produces the RAM write address and enable, the full and almost-full flags, a fill level and a sticky overflow flag.
- Its Gray wptr output feeds the write-to-read synchroniser.

---
 rtl/wptr_full_ctrl.sv | 66 ++++++
 tb/tb_wptr_full_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/wptr_full_ctrl.sv
// wptr_full_ctrl: write-domain Gray/binary pointer, full/almost-full, level and overflow tracking for a dual-clock FIFO
module wptr_full_ctrl #(
    parameter int ASIZE       = 4,
    parameter int AFULL_LEVEL = 14
) (
    input  logic             wclk,
    input  logic             wrst,
    input  logic             winc,
    input  logic             ovf_clr,
    input  logic [ASIZE:0]   wq2_rptr,
    output logic             wen,
    output logic [ASIZE-1:0] waddr,
    output logic [ASIZE:0]   wptr,
    output logic             wfull,
    output logic             walmost_full,
    output logic [ASIZE:0]   wlevel,
    output logic             woverflow
);
    localparam int PW = ASIZE + 1;
    localparam logic [PW-1:0] AFL = PW'(AFULL_LEVEL);

    logic [PW-1:0] wbin_q, wbin_d, wptr_q, wptr_d, wlevel_q, wlevel_d, rbin_sync;
    logic          wfull_q, wfull_d, walmost_full_q, walmost_full_d, woverflow_q, woverflow_d;

    // Gray-to-binary: each bit is the XOR of itself and all higher Gray bits
    always_comb begin
        rbin_sync = '0;
        for (int i = 0; i < PW; i++)
            rbin_sync[i] = ^(wq2_rptr >> i);
    end

    always_comb begin
        wen            = winc & ~wfull_q;
        wbin_d         = wbin_q + {{ASIZE{1'b0}}, wen};
        wptr_d         = (wbin_d >> 1) ^ wbin_d;
        wfull_d        = wptr_d == {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]};
        wlevel_d       = wbin_d - rbin_sync;
        walmost_full_d = wlevel_d >= AFL;
        woverflow_d    = (winc & wfull_q) | (woverflow_q & ~ovf_clr);
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wbin_q         <= '0;
            wptr_q         <= '0;
            wlevel_q       <= '0;
            wfull_q        <= 1'b0;
            walmost_full_q <= 1'b0;
            woverflow_q    <= 1'b0;
        end else begin
            wbin_q         <= wbin_d;
            wptr_q         <= wptr_d;
            wlevel_q       <= wlevel_d;
            wfull_q        <= wfull_d;
            walmost_full_q <= walmost_full_d;
            woverflow_q    <= woverflow_d;
        end
    end

    assign waddr        = wbin_q[ASIZE-1:0];
    assign wptr         = wptr_q;
    assign wfull        = wfull_q;
    assign walmost_full = walmost_full_q;
    assign wlevel       = wlevel_q;
    assign woverflow    = woverflow_q;
endmodule

// File: tb/tb_wptr_full_ctrl.sv
// tb_wptr_full_ctrl: directed checks of fill, overflow, drain, wrap, simultaneous access and async reset
module tb_wptr_full_ctrl;
    logic       wclk = 1'b0;
    logic       wrst, winc, ovf_clr;
    logic [4:0] wq2_rptr;
    logic       wen, wfull, walmost_full, woverflow;
    logic [3:0] waddr;
    logic [4:0] wptr, wlevel;
    int checks = 0;
    int errors = 0;

    wptr_full_ctrl #(.ASIZE(4), .AFULL_LEVEL(14)) dut (
        .wclk(wclk), .wrst(wrst), .winc(winc), .ovf_clr(ovf_clr), .wq2_rptr(wq2_rptr),
        .wen(wen), .waddr(waddr), .wptr(wptr), .wfull(wfull),
        .walmost_full(walmost_full), .wlevel(wlevel), .woverflow(woverflow)
    );

    always #5 wclk = ~wclk;

    function automatic logic [4:0] gray(input int b);
        logic [4:0] v;
        v = 5'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge wclk);
        #1;
    endtask

    initial begin
        wrst = 1'b1; winc = 1'b1; ovf_clr = 1'b0; wq2_rptr = 5'b0;
        #2;
        chk("rst_wptr", wptr, 0);
        chk("rst_wfull", wfull, 0);
        chk("rst_af", walmost_full, 0);
        chk("rst_wlevel", wlevel, 0);
        chk("rst_ovf", woverflow, 0);
        chk("rst_wen_follows_winc", wen, 1);
        winc = 1'b0;
        tick;
        wrst = 1'b0;
        winc = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) begin
            chk("fill_wen", wen, 1);
            chk("fill_waddr", waddr, i);
            tick;
            if (i == 12) chk("fill_af_13", walmost_full, 0);
            if (i == 13) chk("fill_af_14", walmost_full, 1);
        end
        chk("full_wfull", wfull, 1);
        chk("full_wlevel", wlevel, 16);
        chk("full_wptr", wptr, 5'b11000);
        chk("ovf_wen", wen, 0);
        tick;
        tick;
        chk("ovf_wptr", wptr, 5'b11000);
        chk("ovf_set", woverflow, 1);
        chk("ovf_wlevel", wlevel, 16);
        winc = 1'b0; ovf_clr = 1'b1;
        tick;
        chk("ovf_clr", woverflow, 0);
        winc = 1'b1;
        tick;
        chk("ovf_set_wins", woverflow, 1);
        winc = 1'b0;
        tick;
        ovf_clr = 1'b0;
        chk("ovf_clr2", woverflow, 0);
        wq2_rptr = 5'b00001;
        tick;
        chk("drain1_wfull", wfull, 0);
        chk("drain1_wlevel", wlevel, 15);
        chk("drain1_af", walmost_full, 1);
        wq2_rptr = 5'b00011;
        tick;
        chk("drain2_wlevel", wlevel, 14);
        chk("drain2_af", walmost_full, 1);
        wq2_rptr = 5'b00010;
        tick;
        chk("drain3_wlevel", wlevel, 13);
        chk("drain3_af", walmost_full, 0);
        for (int r = 4; r <= 6; r++) begin
            wq2_rptr = gray(r);
            tick;
        end
        chk("lvl10", wlevel, 10);
        winc = 1'b1;
        wq2_rptr = 5'b00100;
        #1;
        chk("simul_wen", wen, 1);
        tick;
        chk("simul_wlevel", wlevel, 10);
        chk("simul_wptr", wptr, 5'b11001);
        for (int r = 8; r <= 20; r++) begin
            wq2_rptr = gray(r);
            tick;
        end
        chk("walk_wlevel", wlevel, 10);
        chk("walk_waddr", waddr, 14);
        chk("walk_wptr", wptr, 5'b10001);
        winc = 1'b0;
        for (int r = 21; r <= 30; r++) begin
            wq2_rptr = gray(r);
            tick;
        end
        chk("preset_wlevel", wlevel, 0);
        chk("preset_rptr_gray", wq2_rptr, 5'b10001);
        winc = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick;
            if (i == 1) chk("wrap_wptr0", wptr, 0);
            if (i == 1) chk("wrap_waddr0", waddr, 0);
        end
        chk("wrap_wptr", wptr, 5'b01001);
        chk("wrap_wfull", wfull, 1);
        chk("wrap_wlevel", wlevel, 16);
        tick;
        winc = 1'b0;
        chk("wrap_ovf", woverflow, 1);
        for (int r = 31; r <= 37; r++) begin
            wq2_rptr = gray(r);
            tick;
        end
        chk("lvl9_wlevel", wlevel, 9);
        chk("lvl9_ovf", woverflow, 1);
        #2;
        wrst = 1'b1;
        #1;
        chk("arst_wptr", wptr, 0);
        chk("arst_wlevel", wlevel, 0);
        chk("arst_ovf", woverflow, 0);
        chk("arst_wfull", wfull, 0);
        chk("arst_af", walmost_full, 0);
        chk("arst_waddr", waddr, 0);
        #1;
        wrst = 1'b0;
        wq2_rptr = 5'b0;
        winc = 1'b1;
        #1;
        chk("post_wen", wen, 1);
        chk("post_waddr", waddr, 0);
        tick;
        chk("post_wlevel", wlevel, 1);
        chk("post_waddr1", waddr, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
